// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one read outstanding to
// instruction memory and buffers returned words in a 2-entry FIFO for the decoder.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_if,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] req_pc_reg;

  logic [ADDR_W-1:0] fifo_pc   [2];
  logic [31:0]       fifo_data [2];
  logic              rd_ptr_reg, wr_ptr_reg;
  logic [1:0]        count_reg;

  logic       push, pop, issue;
  logic [1:0] occ_after;

  // A redirect discards both the buffered words and any word landing this cycle.
  always_comb begin
    pop       = (count_reg != 2'd0) && !stall_if && !branch_valid;
    push      = (state_reg == WAIT) && imem_ack && !branch_valid;
    occ_after = count_reg + 2'(push) - 2'(pop);
    issue     = !rst && !branch_valid && (occ_after <= 2'd1) &&
                ((state_reg == FETCH) || ((state_reg == WAIT) && imem_ack));
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (branch_valid) begin
      pc_next    = branch_target & ~ADDR_W'(3);
      state_next = ((state_reg != FETCH) && !imem_ack) ? DROP : FETCH;
    end else begin
      if (issue) begin
        pc_next    = pc_reg + ADDR_W'(4);
        state_next = WAIT;
      end else if (imem_ack && (state_reg != FETCH)) begin
        state_next = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (issue) begin
        req_pc_reg <= pc_reg;
      end
    end
  end

  // Issue is only allowed when post-cycle occupancy is <=1, so a push never
  // lands in a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (branch_valid) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr_reg]   <= req_pc_reg;
        fifo_data[wr_ptr_reg] <= imem_rdata;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= occ_after;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign instruction = fifo_data[rd_ptr_reg];
  assign instr_pc    = fifo_pc[rd_ptr_reg];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable memory responder and a
// queue of expected presented PCs that is checked on every consumed instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_if;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall_if     (stall_if),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 1;

  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr  = '0;
  int          pend_due   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];
  logic        last_req, last_ack, last_consumed;
  logic [31:0] last_addr;
  int          first_cons_cyc = -1;
  int          rst_end_cyc    = 0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample the DUT, then advance.
  task automatic step();
    logic [31:0] e;
    if (pend_valid && (pend_due == cyc)) begin
      imem_ack   = 1'b1;
      imem_rdata = word_of(pend_addr);
      pend_valid = 1'b0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    #1;
    last_ack      = imem_ack;
    last_req      = (imem_req === 1'b1);
    last_addr     = imem_addr;
    last_consumed = (instr_valid === 1'b1) && !stall_if && !branch_valid && !rst;
    if (last_req) begin
      check("one_outstanding", 64'(pend_valid), 64'd0);
      pend_valid = 1'b1;
      pend_addr  = imem_addr;
      pend_due   = cyc + lat;
      req_addr_log.push_back(imem_addr);
      req_cyc_log.push_back(cyc);
    end
    if (last_consumed) begin
      $display("cyc %0d: consume pc=%h instr=%h", cyc, instr_pc, instruction);
      if (first_cons_cyc < 0) first_cons_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(e));
        check("instruction", 64'(instruction), 64'(word_of(e)));
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    req_addr_log.delete();
    req_cyc_log.delete();
    first_cons_cyc = -1;
  endtask

  task automatic do_reset(int n);
    int reqs;
    reqs = 0;
    rst  = 1'b1;
    exp_q.delete();
    repeat (n) begin
      step();
      reqs += int'(last_req);
    end
    rst = 1'b0;
    check("reset_req", 64'(reqs), 64'd0);
    check("reset_valid", 64'(instr_valid), 64'd0);
    check("reset_instr", 64'(instruction), 64'd0);
    check("reset_pc", 64'(instr_pc), 64'd0);
    clear_logs();
    rst_end_cyc = cyc;
  endtask

  // Consume with stall_if=0 until every expected entry is seen or the bound expires.
  task automatic run_drain(int bound, bit gap);
    int n;
    int prev;
    n        = 0;
    prev     = -1;
    stall_if = 1'b0;
    while ((exp_q.size() != 0) && (n < bound)) begin
      step();
      n++;
      if (gap && last_consumed) begin
        if (prev >= 0) check("no_gap", 64'(cyc - 1), 64'(prev + 1));
        prev = cyc - 1;
      end
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    stall_if = 1'b1;
  endtask

  task automatic do_branch(logic [31:0] target);
    exp_q.delete();
    clear_logs();
    branch_valid  = 1'b1;
    branch_target = target;
    step();
    branch_valid  = 1'b0;
    check("branch_no_req", 64'(last_req), 64'd0);
    check("branch_flush", 64'(instr_valid), 64'd0);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    stall_if      = 1'b1;
    branch_valid  = 1'b0;
    branch_target = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    @(negedge clk);

    // 1: back-to-back fetch at latency 1
    lat = 1;
    do_reset(3);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    run_drain(40, 1'b1);
    check("first_req_cyc", 64'(req_cyc_log.size() > 0 ? req_cyc_log[0] : -1), 64'(rst_end_cyc));
    check("first_valid_lat", 64'(first_cons_cyc), 64'(rst_end_cyc + 2));
    check("req_log_size", 64'(req_addr_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < req_addr_log.size()) begin
        check("req_addr_seq", 64'(req_addr_log[i]), 64'(i * 4));
        check("req_cyc_seq", 64'(req_cyc_log[i]), 64'(rst_end_cyc + i));
      end
    end

    // 2: stall fills the FIFO, requests stop, presented word held
    lat = 1;
    do_reset(3);
    n = 0;
    while ((instr_valid !== 1'b1) && (n < 10)) begin
      step();
      n++;
    end
    check("fill_valid", 64'(instr_valid), 64'd1);
    n = 0;
    repeat (6) begin
      step();
      n += int'(last_req);
      check("stall_hold_pc", 64'(instr_pc), 64'h0);
      check("stall_hold_instr", 64'(instruction), 64'(word_of(32'h0)));
      check("stall_hold_valid", 64'(instr_valid), 64'd1);
    end
    check("stall_no_req", 64'(n), 64'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    run_drain(20, 1'b1);

    // 3: branch while the request to 0x10 is outstanding (latency 3)
    lat = 3;
    do_reset(3);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    run_drain(40, 1'b0);
    check("drop_setup", 64'(pend_valid && (pend_addr == 32'h10) && (pend_due != cyc)), 64'd1);
    do_branch(32'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    run_drain(40, 1'b0);
    check("drop_first_req", 64'(req_addr_log.size() > 0 ? req_addr_log[0] : 32'hFFFF_FFFF), 64'h100);

    // 4: unaligned target with a full FIFO
    lat = 1;
    do_reset(3);
    repeat (5) step();
    check("full_before_branch", 64'(instr_valid), 64'd1);
    do_branch(32'h103);
    step();
    check("aligned_req", 64'(last_req), 64'd1);
    check("aligned_addr", 64'(last_addr), 64'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    run_drain(20, 1'b0);

    // 5: branch in the same cycle as the ack
    lat = 2;
    do_reset(3);
    n = 0;
    while (!(pend_valid && (pend_due == cyc)) && (n < 10)) begin
      step();
      n++;
    end
    check("ack_setup", 64'(pend_valid && (pend_due == cyc)), 64'd1);
    do_branch(32'h200);
    check("branch_ack_seen", 64'(last_ack), 64'd1);
    step();
    check("target_req", 64'(last_req), 64'd1);
    check("target_addr", 64'(last_addr), 64'h200);
    for (int i = 0; i < 2; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    run_drain(20, 1'b0);

    // 6: reset while waiting; stale ack arrives in the first cycle after reset
    lat = 3;
    do_reset(3);
    step();
    check("wait_setup", 64'(pend_valid), 64'd1);
    rst = 1'b1;
    step();
    check("rst_wait_req0", 64'(last_req), 64'd0);
    step();
    check("rst_wait_req1", 64'(last_req), 64'd0);
    rst = 1'b0;
    check("rst_wait_valid", 64'(instr_valid), 64'd0);
    check("rst_wait_pc", 64'(instr_pc), 64'd0);
    clear_logs();
    step();
    check("stale_ack_seen", 64'(last_ack), 64'd1);
    check("post_rst_req", 64'(last_req), 64'd1);
    check("post_rst_addr", 64'(last_addr), 64'h0);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    run_drain(40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
